xdma_write_arbiter: RTL and testbench
=====================================

Name: xdma_write_arbiter

Overview:
Shares one AXI4 write port (AW/W/B only) among NumIn AXI write requesters in the XDMA adapter; its master port feeds the AXI-to-reqrsp write converter. Round-robin arbitration per burst: grant held from selection until W-last handshake, so bursts never interleave. B responses route back through an in-order FIFO of grant indices. AR/R channels are not handled.

Parameters:
NumIn, 2, number of requester ports (2..8)
AddrWidth, 48, AW address width
DataWidth, 512, W data width; strobe width StrbWidth = DataWidth/8
IdWidth, 4, AXI ID width, passed through unchanged
BFifoDepth, 4, outstanding-burst capacity of the B-routing FIFO (power of 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
busy_o  out  1  high when state != IDLE or B-FIFO non-empty
slv_aw_valid_i / slv_aw_ready_o  in/out  NumIn  per-port AW handshake
slv_aw_addr_i  in  NumIn*AddrWidth  per-port AW address (port k at slice k)
slv_aw_len_i  in  NumIn*8  per-port burst length - 1
slv_aw_size_i  in  NumIn*3  per-port beat size
slv_aw_id_i  in  NumIn*IdWidth  per-port AW ID
slv_w_valid_i / slv_w_ready_o  in/out  NumIn  per-port W handshake
slv_w_data_i  in  NumIn*DataWidth  per-port W data
slv_w_strb_i  in  NumIn*StrbWidth  per-port W strobe
slv_w_last_i  in  NumIn  per-port W last
slv_b_valid_o / slv_b_ready_i  out/in  NumIn  per-port B handshake
slv_b_id_o  out  NumIn*IdWidth  B ID, all ports driven from mst_b_id_i
slv_b_resp_o  out  NumIn*2  B resp, all ports driven from mst_b_resp_i
mst_aw_valid_o / mst_aw_ready_i  out/in  1  master AW handshake
mst_aw_addr_o, mst_aw_len_o, mst_aw_size_o, mst_aw_id_o  out  AddrWidth/8/3/IdWidth  muxed AW payload
mst_w_valid_o / mst_w_ready_i  out/in  1  master W handshake
mst_w_data_o, mst_w_strb_o, mst_w_last_o  out  DataWidth/StrbWidth/1  muxed W payload
mst_b_valid_i / mst_b_ready_o  in/out  1  master B handshake
mst_b_id_i, mst_b_resp_i  in  IdWidth/2  B payload

Behaviour:
- Reset: state IDLE, rr pointer 0, sel_q 0, aw_done_q 0, FIFO empty; all *_valid_o, *_ready_o and busy_o 0; payload outputs 0.
- States: IDLE, GRANT.
- IDLE: candidates = slv_aw_valid_i, masked to 0 when FIFO full. Winner = first set bit searching upward from rr pointer, wrapping. If a winner exists: sel_q <= winner, aw_done_q <= 0, go GRANT. No master valid in IDLE. Arbitration latency is 1 cycle.
- GRANT: mst_aw_valid_o = slv_aw_valid_i[sel_q] & !aw_done_q; mst AW payload = port sel_q; slv_aw_ready_o[sel_q] = mst_aw_ready_i & !aw_done_q; all other readies 0.
- In GRANT, W is forwarded concurrently with AW: mst_w_valid_o = slv_w_valid_i[sel_q]; slv_w_ready_o[sel_q] = mst_w_ready_i. W is not held back until AW completes, because the downstream converter requires aw_valid and w_valid together.
- AW handshake: push sel_q into FIFO, set aw_done_q.
- Exit GRANT on a W handshake with w_last when aw_done_q, or an AW handshake, holds in the same cycle. On exit: rr pointer <= (sel_q+1) mod NumIn, go IDLE. A W-last handshake before the AW handshake keeps GRANT until AW completes.
- Grant stability: sel_q is constant throughout GRANT, so mst valids never drop or change payload while pending.
- B routing: head = FIFO head. slv_b_valid_o[head] = mst_b_valid_i & !empty; other ports 0; mst_b_ready_o = slv_b_ready_i[head] & !empty. Pop on master B handshake. Same-cycle push and pop is allowed; occupancy is unchanged.
- FIFO full blocks new grants only; an in-progress GRANT completes normally.
- Reset mid-burst returns to reset values immediately; outstanding B routing is lost by design.
- B IDs are not inspected; ordering relies on in-order B from downstream.

Test Plan:
- Single port 0, len=3, aw_addr=0x1000, four W beats with last on beat 4 -> one master burst with identical payload; slv_b_valid_o=1 on port 0 only; busy_o returns to 0 after B.
- Ports 0 and 1 both valid at reset, len=0 each, repeated 4 times -> grant order 0,1,0,1 with no W interleaving; B delivered 0,1,0,1.
- Port 1 burst len=7 in progress, port 0 raises aw_valid at beat 2 -> port 0 not granted until beat 8 last handshake, then granted after 1 IDLE cycle.
- Downstream holds b_valid=0, BFifoDepth=4, five single-beat bursts -> fifth is not granted until the first B handshake pops the FIFO.
- mst_aw_ready_i delayed 3 cycles while W beat 0 pending -> mst_aw_valid_o and payload stay stable; aw accepted once; no duplicate FIFO push.
- rst_ni asserted at beat 2 of a len=3 burst -> all valids and readies 0 and FIFO empty the same cycle; a fresh burst after reset completes normally.

Source files
------------

// File: rtl/xdma_write_arbiter.sv
// Round-robin, burst-granular arbiter sharing one AXI4 write port (AW/W/B) among NumIn requesters.
// B responses are routed back through an in-order FIFO of grant indices.
module xdma_write_arbiter #(
  parameter int unsigned NumIn      = 2,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DataWidth  = 512,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned BFifoDepth = 4,
  parameter int unsigned StrbWidth  = DataWidth / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  output logic                           busy_o,
  input  logic [NumIn-1:0]               slv_aw_valid_i,
  output logic [NumIn-1:0]               slv_aw_ready_o,
  input  logic [NumIn*AddrWidth-1:0]     slv_aw_addr_i,
  input  logic [NumIn*8-1:0]             slv_aw_len_i,
  input  logic [NumIn*3-1:0]             slv_aw_size_i,
  input  logic [NumIn*IdWidth-1:0]       slv_aw_id_i,
  input  logic [NumIn-1:0]               slv_w_valid_i,
  output logic [NumIn-1:0]               slv_w_ready_o,
  input  logic [NumIn*DataWidth-1:0]     slv_w_data_i,
  input  logic [NumIn*StrbWidth-1:0]     slv_w_strb_i,
  input  logic [NumIn-1:0]               slv_w_last_i,
  output logic [NumIn-1:0]               slv_b_valid_o,
  input  logic [NumIn-1:0]               slv_b_ready_i,
  output logic [NumIn*IdWidth-1:0]       slv_b_id_o,
  output logic [NumIn*2-1:0]             slv_b_resp_o,
  output logic                           mst_aw_valid_o,
  input  logic                           mst_aw_ready_i,
  output logic [AddrWidth-1:0]           mst_aw_addr_o,
  output logic [7:0]                     mst_aw_len_o,
  output logic [2:0]                     mst_aw_size_o,
  output logic [IdWidth-1:0]             mst_aw_id_o,
  output logic                           mst_w_valid_o,
  input  logic                           mst_w_ready_i,
  output logic [DataWidth-1:0]           mst_w_data_o,
  output logic [StrbWidth-1:0]           mst_w_strb_o,
  output logic                           mst_w_last_o,
  input  logic                           mst_b_valid_i,
  output logic                           mst_b_ready_o,
  input  logic [IdWidth-1:0]             mst_b_id_i,
  input  logic [1:0]                     mst_b_resp_i
);

  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned PtrW = (BFifoDepth > 1) ? $clog2(BFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(BFifoDepth + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   sel_q, sel_d, rr_q, rr_d, winner, idx, head;
  logic              aw_done_q, aw_done_d, wl_done_q, wl_done_d;
  logic              found, aw_push, b_pop, aw_hs, w_last_hs;
  logic [NumIn-1:0]  cand;

  logic [IdxW-1:0]   fifo_q [BFifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              fifo_full, fifo_empty;

  assign fifo_full  = (cnt_q == CntW'(BFifoDepth));
  assign fifo_empty = (cnt_q == '0);
  assign busy_o     = (state_q != IDLE) | ~fifo_empty;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BFifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    rr_d           = rr_q;
    aw_done_d      = aw_done_q;
    wl_done_d      = wl_done_q;
    found          = 1'b0;
    winner         = '0;
    idx            = '0;
    aw_push        = 1'b0;
    aw_hs          = 1'b0;
    w_last_hs      = 1'b0;
    mst_aw_valid_o = 1'b0;
    mst_aw_addr_o  = '0;
    mst_aw_len_o   = '0;
    mst_aw_size_o  = '0;
    mst_aw_id_o    = '0;
    mst_w_valid_o  = 1'b0;
    mst_w_data_o   = '0;
    mst_w_strb_o   = '0;
    mst_w_last_o   = 1'b0;
    slv_aw_ready_o = '0;
    slv_w_ready_o  = '0;

    cand = fifo_full ? '0 : slv_aw_valid_i;
    for (int unsigned i = 0; i < NumIn; i++) begin
      idx = IdxW'((rr_q + i) % NumIn);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d     = winner;
          aw_done_d = 1'b0;
          wl_done_d = 1'b0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        mst_aw_valid_o        = slv_aw_valid_i[sel_q] & ~aw_done_q;
        mst_aw_addr_o         = slv_aw_addr_i[sel_q*AddrWidth +: AddrWidth];
        mst_aw_len_o          = slv_aw_len_i[sel_q*8 +: 8];
        mst_aw_size_o         = slv_aw_size_i[sel_q*3 +: 3];
        mst_aw_id_o           = slv_aw_id_i[sel_q*IdWidth +: IdWidth];
        slv_aw_ready_o[sel_q] = mst_aw_ready_i & ~aw_done_q;
        mst_w_valid_o         = slv_w_valid_i[sel_q];
        mst_w_data_o          = slv_w_data_i[sel_q*DataWidth +: DataWidth];
        mst_w_strb_o          = slv_w_strb_i[sel_q*StrbWidth +: StrbWidth];
        mst_w_last_o          = slv_w_last_i[sel_q];
        slv_w_ready_o[sel_q]  = mst_w_ready_i;

        aw_hs     = mst_aw_valid_o & mst_aw_ready_i;
        w_last_hs = mst_w_valid_o & mst_w_ready_i & mst_w_last_o;
        aw_push   = aw_hs;
        if (aw_hs)     aw_done_d = 1'b1;
        if (w_last_hs) wl_done_d = 1'b1;
        // An early W-last is remembered so the grant can still close on the later AW handshake.
        if ((w_last_hs | wl_done_q) & (aw_hs | aw_done_q)) begin
          state_d = IDLE;
          rr_d    = (sel_q == IdxW'(NumIn - 1)) ? '0 : sel_q + IdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rr_q      <= '0;
      aw_done_q <= 1'b0;
      wl_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      aw_done_q <= aw_done_d;
      wl_done_q <= wl_done_d;
    end
  end

  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    slv_b_valid_o       = '0;
    slv_b_valid_o[head] = mst_b_valid_i & ~fifo_empty;
    mst_b_ready_o       = slv_b_ready_i[head] & ~fifo_empty;
  end

  assign b_pop        = mst_b_valid_i & mst_b_ready_o;
  assign slv_b_id_o   = {NumIn{mst_b_id_i}};
  assign slv_b_resp_o = {NumIn{mst_b_resp_i}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < BFifoDepth; i++) fifo_q[i] <= '0;
    end else begin
      if (aw_push) begin
        fifo_q[wr_ptr_q] <= sel_q;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (b_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (aw_push && !b_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!aw_push && b_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: tb/tb_xdma_write_arbiter.sv
// Directed bench for xdma_write_arbiter: table of single-port bursts plus multi-cycle corner sequences.
module tb_xdma_write_arbiter;
  localparam int N  = 2;
  localparam int AW = 48;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;
  localparam int FD = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            busy_o;
  logic [N-1:0]    slv_aw_valid_i, slv_aw_ready_o;
  logic [N*AW-1:0] slv_aw_addr_i;
  logic [N*8-1:0]  slv_aw_len_i;
  logic [N*3-1:0]  slv_aw_size_i;
  logic [N*IW-1:0] slv_aw_id_i;
  logic [N-1:0]    slv_w_valid_i, slv_w_ready_o;
  logic [N*DW-1:0] slv_w_data_i;
  logic [N*SW-1:0] slv_w_strb_i;
  logic [N-1:0]    slv_w_last_i;
  logic [N-1:0]    slv_b_valid_o, slv_b_ready_i;
  logic [N*IW-1:0] slv_b_id_o;
  logic [N*2-1:0]  slv_b_resp_o;
  logic            mst_aw_valid_o, mst_aw_ready_i;
  logic [AW-1:0]   mst_aw_addr_o;
  logic [7:0]      mst_aw_len_o;
  logic [2:0]      mst_aw_size_o;
  logic [IW-1:0]   mst_aw_id_o;
  logic            mst_w_valid_o, mst_w_ready_i;
  logic [DW-1:0]   mst_w_data_o;
  logic [SW-1:0]   mst_w_strb_o;
  logic            mst_w_last_o;
  logic            mst_b_valid_i, mst_b_ready_o;
  logic [IW-1:0]   mst_b_id_i;
  logic [1:0]      mst_b_resp_i;

  int total = 0;
  int bad   = 0;

  xdma_write_arbiter #(
    .NumIn(N), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .BFifoDepth(FD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .busy_o(busy_o),
    .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
    .slv_aw_addr_i(slv_aw_addr_i), .slv_aw_len_i(slv_aw_len_i),
    .slv_aw_size_i(slv_aw_size_i), .slv_aw_id_i(slv_aw_id_i),
    .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o),
    .slv_w_data_i(slv_w_data_i), .slv_w_strb_i(slv_w_strb_i), .slv_w_last_i(slv_w_last_i),
    .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i),
    .slv_b_id_o(slv_b_id_o), .slv_b_resp_o(slv_b_resp_o),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_len_o(mst_aw_len_o),
    .mst_aw_size_o(mst_aw_size_o), .mst_aw_id_o(mst_aw_id_o),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o), .mst_w_last_o(mst_w_last_o),
    .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o),
    .mst_b_id_i(mst_b_id_i), .mst_b_resp_i(mst_b_resp_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          port;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [31:0] d0;
    logic [1:0]  resp;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [47:0] a, input logic [7:0] l,
                          input logic [3:0] id, input logic [31:0] d, input logic last);
    slv_aw_addr_i[p*AW +: AW] = a;
    slv_aw_len_i[p*8 +: 8]    = l;
    slv_aw_size_i[p*3 +: 3]   = 3'd2;
    slv_aw_id_i[p*IW +: IW]   = id;
    slv_w_data_i[p*DW +: DW]  = d;
    slv_w_strb_i[p*SW +: SW]  = '1;
    slv_w_last_i[p]           = last;
  endtask

  task automatic clear_inputs();
    slv_aw_valid_i = '0; slv_aw_addr_i = '0; slv_aw_len_i = '0; slv_aw_size_i = '0;
    slv_aw_id_i = '0; slv_w_valid_i = '0; slv_w_data_i = '0; slv_w_strb_i = '0;
    slv_w_last_i = '0; slv_b_ready_i = '1; mst_aw_ready_i = 1'b1; mst_w_ready_i = 1'b1;
    mst_b_valid_i = 1'b0; mst_b_id_i = '0; mst_b_resp_i = '0;
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Drives one burst from port p with an always-ready master; starts and ends at posedge+1.
  task automatic do_burst(input int p, input logic [47:0] a, input logic [7:0] l,
                          input logic [3:0] id, input logic [31:0] d0);
    int beat = 0;
    int guard = 0;
    bit aw_pend = 1'b1;
    bit awhs, whs;
    logic [N-1:0] oh;
    oh = '0; oh[p] = 1'b1;
    mst_aw_ready_i = 1'b1; mst_w_ready_i = 1'b1;
    set_port(p, a, l, id, d0, l == 8'd0);
    slv_aw_valid_i[p] = 1'b1; slv_w_valid_i[p] = 1'b1;
    @(negedge clk_i);
    chk("arb_latency_aw_valid", mst_aw_valid_o, 0);
    @(posedge clk_i); #1;
    while ((aw_pend || beat <= int'(l)) && guard < 100) begin
      @(negedge clk_i);
      if (mst_aw_valid_o) begin
        chk("aw_addr", mst_aw_addr_o, a);
        chk("aw_len", mst_aw_len_o, l);
        chk("aw_id", mst_aw_id_o, id);
        chk("aw_size", mst_aw_size_o, 3'd2);
        chk("aw_ready_route", slv_aw_ready_o, oh);
      end
      if (mst_w_valid_o) begin
        chk("w_data", mst_w_data_o, d0 + beat);
        chk("w_last", mst_w_last_o, beat == int'(l));
        chk("w_strb", mst_w_strb_o, 4'hF);
        chk("w_ready_route", slv_w_ready_o, oh);
      end
      awhs = mst_aw_valid_o & mst_aw_ready_i;
      whs  = mst_w_valid_o & mst_w_ready_i;
      @(posedge clk_i); #1;
      if (awhs) begin aw_pend = 1'b0; slv_aw_valid_i[p] = 1'b0; end
      if (whs) begin
        beat++;
        if (beat > int'(l)) slv_w_valid_i[p] = 1'b0;
        else begin
          slv_w_data_i[p*DW +: DW] = d0 + beat;
          slv_w_last_i[p] = (beat == int'(l));
        end
      end
      guard++;
    end
    if (guard >= 100) chk("burst_timeout", 0, 1);
    slv_aw_valid_i[p] = 1'b0; slv_w_valid_i[p] = 1'b0;
  endtask

  task automatic do_b(input int p, input logic [3:0] id, input logic [1:0] resp);
    logic [N-1:0] oh;
    oh = '0; oh[p] = 1'b1;
    mst_b_valid_i = 1'b1; mst_b_id_i = id; mst_b_resp_i = resp;
    @(negedge clk_i);
    chk("b_valid_route", slv_b_valid_o, oh);
    chk("b_id", slv_b_id_o[p*IW +: IW], id);
    chk("b_resp", slv_b_resp_o[p*2 +: 2], resp);
    chk("b_ready", mst_b_ready_o, 1);
    @(posedge clk_i); #1;
    mst_b_valid_i = 1'b0;
  endtask

  int order_exp[4] = '{0, 1, 0, 1};

  initial begin
    int n, cyc, g0, l1, b1, cnt0, cnt1;
    bit raised, p0done, p0hs, whs1, awhs1;
    logic [N-1:0] hs;

    tbl[0] = '{port: 0, addr: 48'h0000_0000_1000, len: 8'd3, id: 4'h5, d0: 32'h1111_0000, resp: 2'd0};
    tbl[1] = '{port: 1, addr: 48'h0000_2000_0040, len: 8'd1, id: 4'h3, d0: 32'h2222_0000, resp: 2'd2};
    tbl[2] = '{port: 0, addr: 48'hFFFF_FFFF_FFC0, len: 8'd0, id: 4'hF, d0: 32'hDEAD_0000, resp: 2'd1};
    tbl[3] = '{port: 1, addr: 48'h0000_0000_0040, len: 8'd2, id: 4'h0, d0: 32'h4444_0000, resp: 2'd3};

    clear_inputs();
    rst_ni = 1'b0;
    #1;
    chk("rst_mst_aw_valid", mst_aw_valid_o, 0);
    chk("rst_mst_w_valid", mst_w_valid_o, 0);
    chk("rst_mst_b_ready", mst_b_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_slv_aw_ready", slv_aw_ready_o, 0);
    chk("rst_slv_w_ready", slv_w_ready_o, 0);
    chk("rst_aw_addr", mst_aw_addr_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1 rst_ni = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_burst(tbl[i].port, tbl[i].addr, tbl[i].len, tbl[i].id, tbl[i].d0);
      @(negedge clk_i);
      chk("busy_before_b", busy_o, 1);
      @(posedge clk_i); #1;
      do_b(tbl[i].port, tbl[i].id, tbl[i].resp);
      @(negedge clk_i);
      chk("busy_after_b", busy_o, 0);
      @(posedge clk_i); #1;
    end

    // Round robin from reset with both ports requesting
    pulse_reset();
    set_port(0, 48'hA000, 8'd0, 4'd0, 32'hA0, 1'b1);
    set_port(1, 48'hA100, 8'd0, 4'd1, 32'hA1, 1'b1);
    slv_aw_valid_i = 2'b11; slv_w_valid_i = 2'b11;
    cnt0 = 2; cnt1 = 2; n = 0; cyc = 0;
    while (n < 4 && cyc < 30) begin
      @(negedge clk_i);
      hs = slv_aw_ready_o & slv_aw_valid_i;
      if (mst_aw_valid_o) begin
        chk("rr_order", slv_aw_ready_o[1], order_exp[n]);
        chk("rr_wdata", mst_w_data_o, 32'hA0 + order_exp[n]);
        n++;
      end
      @(posedge clk_i); #1;
      if (hs[0]) begin cnt0--; if (cnt0 == 0) begin slv_aw_valid_i[0] = 0; slv_w_valid_i[0] = 0; end end
      if (hs[1]) begin cnt1--; if (cnt1 == 0) begin slv_aw_valid_i[1] = 0; slv_w_valid_i[1] = 0; end end
      cyc++;
    end
    chk("rr_grant_count", n, 4);
    slv_aw_valid_i = '0; slv_w_valid_i = '0;
    for (int k = 0; k < 4; k++) do_b(order_exp[k], 4'(order_exp[k]), 2'd0);

    // Long burst on port 1 holds off port 0 until its last beat
    set_port(1, 48'h3000, 8'd7, 4'd1, 32'h3000_0000, 1'b0);
    slv_aw_valid_i[1] = 1'b1; slv_w_valid_i[1] = 1'b1;
    b1 = 0; cyc = 0; g0 = -1; l1 = -1; raised = 0; p0done = 0;
    while (!p0done && cyc < 40) begin
      @(negedge clk_i);
      awhs1 = slv_aw_ready_o[1] & slv_aw_valid_i[1];
      whs1  = slv_w_ready_o[1] & slv_w_valid_i[1];
      p0hs  = slv_aw_ready_o[0] & slv_aw_valid_i[0];
      if (whs1) chk("lb_p1_wdata", mst_w_data_o, 32'h3000_0000 + b1);
      if (whs1 && b1 == 7) l1 = cyc;
      if (p0hs && g0 < 0) begin
        g0 = cyc;
        chk("lb_p0_wdata", mst_w_data_o, 32'h0B0B_0000);
      end
      @(posedge clk_i); #1;
      if (awhs1) slv_aw_valid_i[1] = 1'b0;
      if (whs1) begin
        b1++;
        if (b1 == 8) slv_w_valid_i[1] = 1'b0;
        else begin
          slv_w_data_i[DW +: DW] = 32'h3000_0000 + b1;
          slv_w_last_i[1] = (b1 == 7);
        end
      end
      if (b1 == 2 && !raised) begin
        raised = 1;
        set_port(0, 48'h0B00, 8'd0, 4'd2, 32'h0B0B_0000, 1'b1);
        slv_aw_valid_i[0] = 1'b1; slv_w_valid_i[0] = 1'b1;
      end
      if (p0hs) begin slv_aw_valid_i[0] = 1'b0; slv_w_valid_i[0] = 1'b0; p0done = 1; end
      cyc++;
    end
    chk("lb_p0_done", p0done, 1);
    chk("lb_grant_gap", 64'(g0 - l1), 64'd2);
    do_b(1, 4'd1, 2'd0);
    do_b(0, 4'd2, 2'd0);

    // FIFO full blocks the fifth grant until a B pops
    for (int k = 0; k < 4; k++) do_burst(0, 48'h6000 + 48'(k * 64), 8'd0, 4'(k), 32'h6000_0000 + k);
    set_port(0, 48'h6400, 8'd0, 4'd4, 32'h6000_0004, 1'b1);
    slv_aw_valid_i[0] = 1'b1; slv_w_valid_i[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("full_blocks_grant", mst_aw_valid_o, 0);
      chk("full_busy", busy_o, 1);
      @(posedge clk_i); #1;
    end
    do_b(0, 4'd0, 2'd0);
    do_burst(0, 48'h6400, 8'd0, 4'd4, 32'h6000_0004);
    for (int k = 1; k < 5; k++) do_b(0, 4'(k), 2'd0);
    @(negedge clk_i);
    chk("full_drained_busy", busy_o, 0);
    @(posedge clk_i); #1;

    // Delayed AW ready: payload stable, single FIFO push
    mst_aw_ready_i = 1'b0; mst_w_ready_i = 1'b0;
    set_port(1, 48'h5555_0000, 8'd1, 4'd9, 32'h5000_0000, 1'b0);
    slv_aw_valid_i[1] = 1'b1; slv_w_valid_i[1] = 1'b1;
    @(negedge clk_i); @(posedge clk_i); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("awd_valid_held", mst_aw_valid_o, 1);
      chk("awd_addr_stable", mst_aw_addr_o, 48'h5555_0000);
      chk("awd_w_valid", mst_w_valid_o, 1);
      chk("awd_slv_aw_ready", slv_aw_ready_o, 0);
      @(posedge clk_i); #1;
    end
    mst_aw_ready_i = 1'b1; mst_w_ready_i = 1'b1;
    @(negedge clk_i);
    chk("awd_accept", slv_aw_ready_o, 2'b10);
    chk("awd_w_accept", slv_w_ready_o, 2'b10);
    @(posedge clk_i); #1;
    slv_w_data_i[DW +: DW] = 32'h5000_0001; slv_w_last_i[1] = 1'b1;
    @(negedge clk_i);
    chk("awd_no_second_aw", mst_aw_valid_o, 0);
    chk("awd_beat1", mst_w_data_o, 32'h5000_0001);
    @(posedge clk_i); #1;
    slv_aw_valid_i = '0; slv_w_valid_i = '0;
    do_b(1, 4'd9, 2'd0);
    @(negedge clk_i);
    chk("awd_single_push", busy_o, 0);
    @(posedge clk_i); #1;

    // Reset in the middle of a burst
    set_port(0, 48'h7000, 8'd3, 4'd7, 32'h7000_0000, 1'b0);
    slv_aw_valid_i[0] = 1'b1; slv_w_valid_i[0] = 1'b1;
    @(negedge clk_i); @(posedge clk_i); #1;
    slv_aw_valid_i[0] = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk_i); @(posedge clk_i); #1;
      slv_w_data_i[0 +: DW] = 32'h7000_0000 + k;
    end
    mst_b_valid_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("mrst_aw_valid", mst_aw_valid_o, 0);
    chk("mrst_w_valid", mst_w_valid_o, 0);
    chk("mrst_w_ready", slv_w_ready_o, 0);
    chk("mrst_b_valid", slv_b_valid_o, 0);
    chk("mrst_b_ready", mst_b_ready_o, 0);
    chk("mrst_busy", busy_o, 0);
    clear_inputs();
    @(posedge clk_i); #1 rst_ni = 1'b1;
    do_burst(0, 48'h8000, 8'd1, 4'd8, 32'h8000_0000);
    do_b(0, 4'd8, 2'd0);
    @(negedge clk_i);
    chk("post_rst_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
